// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier: one partial product per RUN cycle.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     p
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [PW-1:0]      mcand;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      acc_step_c;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               last_step_c;
    logic               load_c;

    // Next-state, shift-add step and operand-capture decode
    always_comb begin
        state_next  = state;
        load_c      = 1'b0;
        acc_step_c  = acc + (mplier[0] ? mcand : PW'(0));
        last_step_c = (cnt == CNT_W'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_EXIT_EN
        // Shifted multiplier empty: no further partial products can contribute
        if (mplier[WIDTH-1:1] == '0) begin
            last_step_c = 1'b1;
        end
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    load_c     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_step_c) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; status flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
        end
    end

    // Datapath: p only updates with the completed product
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
        end else if (load_c) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_step_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_step_c) begin
                p <= acc_step_c;
            end
        end
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned multiplicand.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned multiplier.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking p valid.
REQ-009 The block SHALL have port p, output, 2*WIDTH bits: unsigned product a*b.

Function
REQ-010 The block SHALL implement the FSM states IDLE, RUN and DONE, with the state held in registers.
REQ-011 In IDLE or DONE, start=1 at a rising edge SHALL latch a into the multiplicand register, zero-extended to 2*WIDTH, latch b into the multiplier register, clear the accumulator and step counter, and enter RUN.
REQ-012 In IDLE or DONE, start=0 at a rising edge SHALL move the FSM to IDLE, or keep it there.
REQ-013 Each RUN cycle SHALL perform one shift-add step: if multiplier[0]=1, acc+=multiplicand. The multiplicand SHALL then shift left 1, the multiplier shift right 1, and the counter increment.
REQ-014 Accumulation SHALL be 2*WIDTH bits wide, and no overflow SHALL be possible.
REQ-015 RUN SHALL exit to DONE after exactly WIDTH steps (macro absent).
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, p SHALL equal a*b, and busy SHALL be 0.
REQ-017 p SHALL hold its last result until the next DONE, and SHALL never show partial sums.
REQ-018 busy SHALL be 1 in RUN only.
REQ-019 done SHALL be 0 outside DONE.
REQ-020 start, a and b SHALL be ignored while in RUN; an operation in flight SHALL NOT be disturbed.
REQ-021 Start sampled at edge t0 SHALL give done=1 in the cycle after edge t0+WIDTH; done SHALL be followed by a new busy one cycle later if start=1 during DONE (back-to-back, no idle gap).
REQ-022 Operand changes after the capture edge SHALL NOT affect the result.
REQ-023 Zero operands SHALL produce p=0 with the normal latency (macro absent).

Reset
REQ-024 rst=1 at a rising edge SHALL force: state=IDLE, busy=0, done=0, p=0, and accumulator, counter and operand registers to 0.
REQ-025 rst SHALL take priority over start in every state.
REQ-026 rst during RUN SHALL abort the operation with no done pulse; p SHALL read 0.
REQ-027 The first start after rst is released SHALL behave as from power-up IDLE.

Configuration
REQ-028 Macro SEQ_MULT_EARLY_EXIT_EN, when defined, SHALL end RUN after the step in which the shifted multiplier becomes 0, with a minimum of 1 step and a maximum of WIDTH steps.
REQ-029 With SEQ_MULT_EARLY_EXIT_EN defined, latency SHALL be max(1, index of highest set bit of b + 1) steps plus the DONE cycle, and b=0 SHALL complete after 1 step.
REQ-030 With SEQ_MULT_EARLY_EXIT_EN undefined, latency SHALL be fixed at WIDTH steps, and no early-exit logic SHALL be synthesised.
REQ-031 p values SHALL be identical with and without SEQ_MULT_EARLY_EXIT_EN.

Verification (WIDTH=4 unless stated)
REQ-032 a=15, b=15, start one cycle -> busy 4 cycles, then done=1 one cycle, p=225.
REQ-033 Exhaustive sweep of a,b over 0..15 (256 ops) -> every p equals a*b; macro undefined: every latency 4 steps.
REQ-034 Start held high continuously with a=3,b=5 then a=7,b=9 presented at the second capture -> p=15 then p=63, and done pulses 5 cycles apart.
REQ-035 a=9, b=6 started, then a=0, b=0, start=1 during RUN -> change ignored, p=54.
REQ-036 rst asserted at step 2 of a=12, b=11 -> busy=0, done never pulses, p=0; the next start with a=2, b=3 -> p=6.
REQ-037 SEQ_MULT_EARLY_EXIT_EN defined: b=1 -> done after 1 step; b=0 -> p=0 after 1 step; b=8 -> 4 steps; and with WIDTH=8, a=255, b=255 -> p=65025.
